// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard, forwarding and memory-wait control for a 5-stage pipeline
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic [4:0]  i_ID_Rs1,
  input  logic [4:0]  i_ID_Rs2,
  input  logic        i_ID_Rs1Used,
  input  logic        i_ID_Rs2Used,
  input  logic [4:0]  i_EX_Rs1,
  input  logic [4:0]  i_EX_Rs2,
  input  logic [4:0]  i_EX_Rd,
  input  logic        i_EX_RegWrite,
  input  logic        i_EX_MemRead,
  input  logic        i_EX_BranchTaken,
  input  logic [4:0]  i_MEM_Rd,
  input  logic        i_MEM_RegWrite,
  input  logic        i_MEM_Req,
  input  logic        i_MEM_Ack,
  input  logic [4:0]  i_WB_Rd,
  input  logic        i_WB_RegWrite,
  output logic        o_StallPC,
  output logic        o_StallIFID,
  output logic        o_StallIDEX,
  output logic        o_StallEXMEM,
  output logic        o_FlushIFID,
  output logic        o_FlushIDEX,
  output logic        o_FlushMEMWB,
  output logic        o_PCSelBranch,
  output logic [1:0]  o_FwdA,
  output logic [1:0]  o_FwdB,
  output logic        o_Halted,
  output logic        o_MemFault,
  output logic [15:0] o_StallCycles
);
  localparam logic [1:0] RUN = 2'd0, MEM_WAIT = 2'd1, FAULT = 2'd2;
  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);
  logic [1:0] state;
  logic [7:0] wait_cnt;
  logic       fault_d, fault, mem_stall, load_use, branch, lu_stall;
  assign fault     = state == FAULT;
  assign mem_stall = state == MEM_WAIT || (state == RUN && i_MEM_Req && !i_MEM_Ack);
  assign load_use  = i_EX_MemRead && i_EX_Rd != 5'd0 &&
                     ((i_ID_Rs1Used && i_ID_Rs1 == i_EX_Rd) || (i_ID_Rs2Used && i_ID_Rs2 == i_EX_Rd));
  assign branch    = state == RUN && !mem_stall && i_EX_BranchTaken;
  assign lu_stall  = state == RUN && !mem_stall && !i_EX_BranchTaken && load_use;
  assign o_StallPC     = fault || mem_stall || lu_stall;
  assign o_StallIFID   = o_StallPC;
  assign o_StallIDEX   = fault || mem_stall;
  assign o_StallEXMEM  = fault || mem_stall;
  assign o_FlushMEMWB  = fault || mem_stall;
  assign o_FlushIFID   = branch;
  assign o_FlushIDEX   = branch || lu_stall;
  assign o_PCSelBranch = branch;
  assign o_FwdA = (i_MEM_RegWrite && i_MEM_Rd != 5'd0 && i_MEM_Rd == i_EX_Rs1) ? 2'b10 :
                  (i_WB_RegWrite && i_WB_Rd != 5'd0 && i_WB_Rd == i_EX_Rs1) ? 2'b01 : 2'b00;
  assign o_FwdB = (i_MEM_RegWrite && i_MEM_Rd != 5'd0 && i_MEM_Rd == i_EX_Rs2) ? 2'b10 :
                  (i_WB_RegWrite && i_WB_Rd != 5'd0 && i_WB_Rd == i_EX_Rs2) ? 2'b01 : 2'b00;
  assign o_Halted   = fault;
  assign o_MemFault = fault && !fault_d;
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      state         <= RUN;
      wait_cnt      <= 8'd0;
      fault_d       <= 1'b0;
      o_StallCycles <= 16'd0;
    end else begin
      case (state)
        RUN: if (i_MEM_Req && !i_MEM_Ack) begin
          state    <= MEM_WAIT;
          wait_cnt <= 8'd1;
        end
        MEM_WAIT: if (i_MEM_Ack) state <= RUN;
          else if (wait_cnt == TMO) state <= FAULT;
          else wait_cnt <= wait_cnt + 8'd1;
        default: state <= FAULT;
      endcase
      fault_d <= fault;
      if (o_StallPC && o_StallCycles != 16'hFFFF) o_StallCycles <= o_StallCycles + 16'd1;
    end
  end
endmodule
